// File: rtl/rf_pkg.sv
// Shared widths, the zero-register constant and the writeback request record
// used by the register-file write-side front end.
package rf_pkg;
  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  localparam logic [RF_AW-1:0] RF_ZERO_ADDR = '0;

  typedef struct packed {
    logic             valid;
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of queued load results with per-entry valid, address-based
// invalidation and two address-match query ports for hazard detection.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [AW-1:0]          push_addr,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  input  logic                   inv,
  input  logic [AW-1:0]          inv_addr,
  input  logic [AW-1:0]          qa1,
  input  logic [AW-1:0]          qa2,
  output logic                   head_valid,
  output logic [AW-1:0]          head_addr,
  output logic [DW-1:0]          head_data,
  output logic                   match1,
  output logic                   match2,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [PW:0]      count_q;

  // Later assignments win: a pop clears the head and a push marks the tail live,
  // so a killed entry still occupies its slot until it reaches the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (inv && vld_q[i] && (addr_q[i] == inv_addr)) vld_q[i] <= 1'b0;
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
  end

  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == qa1)) match1 = 1'b1;
      if (vld_q[i] && (addr_q[i] == qa2)) match2 = 1'b1;
    end
  end

  assign head_valid = vld_q[head_q];
  assign head_addr  = addr_q[head_q];
  assign head_data  = data_q[head_q];
  assign count      = count_q;
endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges the ALU writeback path (priority, no backpressure) and the handshaked
// load path onto the single register-file write port, and flags read hazards.
module rf_writeback_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_we,
  input  logic [AW-1:0]          alu_wa,
  input  logic [DW-1:0]          alu_wd,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [AW-1:0]          ld_wa,
  input  logic [DW-1:0]          ld_wd,
  input  logic [AW-1:0]          ra1,
  input  logic [AW-1:0]          ra2,
  output logic                   hz1,
  output logic                   hz2,
  output logic                   we,
  output logic [AW-1:0]          wa,
  output logic [DW-1:0]          wd,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_req;
  logic          ld_hs;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          head_valid;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          match1;
  logic          match2;
  wb_req_t       issue_p0;

  assign alu_req    = alu_we && (alu_wa != RF_ZERO_ADDR);
  assign ld_ready   = (count < CW'(DEPTH));
  assign ld_hs      = ld_valid && ld_ready;
  assign fifo_empty = (count == '0);

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_addr  (ld_wa),
    .push_data  (ld_wd),
    .pop        (pop),
    .inv        (alu_req),
    .inv_addr   (alu_wa),
    .qa1        (ra1),
    .qa2        (ra2),
    .head_valid (head_valid),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .match1     (match1),
    .match2     (match2),
    .count      (count)
  );

  // Arbitration: ALU, then FIFO head, then direct load bypass. Loads to r0, or
  // to the register the ALU overwrites this cycle, are accepted and dropped.
  always_comb begin
    issue_p0 = '0;
    push     = 1'b0;
    pop      = 1'b0;
    if (alu_req) begin
      issue_p0 = '{valid: 1'b1, addr: alu_wa, data: alu_wd};
      push     = ld_hs && (ld_wa != RF_ZERO_ADDR) && (ld_wa != alu_wa);
    end else if (!fifo_empty) begin
      pop      = 1'b1;
      issue_p0 = '{valid: head_valid, addr: head_addr, data: head_data};
      push     = ld_hs && (ld_wa != RF_ZERO_ADDR);
    end else if (ld_hs && (ld_wa != RF_ZERO_ADDR)) begin
      issue_p0 = '{valid: 1'b1, addr: ld_wa, data: ld_wd};
    end
  end

  // Write-port register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we <= 1'b0;
      wa <= '0;
      wd <= '0;
    end else begin
      we <= issue_p0.valid;
      if (issue_p0.valid) begin
        wa <= issue_p0.addr;
        wd <= issue_p0.data;
      end
    end
  end

  assign hz1 = (ra1 != RF_ZERO_ADDR) && (match1 || (we && (wa == ra1)));
  assign hz2 = (ra2 != RF_ZERO_ADDR) && (match2 || (we && (wa == ra2)));
endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Write-side front end for the 32x32 register file (two read ports, one write port, r0 hardwired to zero).
- Merges two writeback sources onto the single write port:
  - the single-cycle ALU result path, which has priority and no backpressure;
  - the multi-cycle load path, which uses a valid/ready handshake.
- Load results that lose arbitration wait in a small FIFO.
- Reports read hazards so decode can stall while a pending write targets a source register.

Parameters:
DEPTH, 4, load-result FIFO entries (power of two, >=2)
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_we  in  1  ALU writeback request this cycle
alu_wa  in  AW  ALU destination register
alu_wd  in  DW  ALU result
ld_valid  in  1  load result offered
ld_ready  out  1  load result accepted when ld_valid&&ld_ready
ld_wa  in  AW  load destination register
ld_wd  in  DW  load data
ra1  in  AW  decode source address 1
ra2  in  AW  decode source address 2
hz1  out  1  ra1 has a pending (not yet committed) write
hz2  out  1  ra2 has a pending write
we  out  1  register-file write enable (registered)
wa  out  AW  register-file write address (registered)
wd  out  DW  register-file write data (registered)
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n=0):
  - we=0, wa=0, wd=0, count=0, all FIFO entries invalid.
  - ld_ready=1 once rst_n=1.
  - Reset mid-operation discards all queued loads, with no write issued.
- Outputs we/wa/wd are registered. A request arbitrated in cycle N drives the port in cycle N+1, and the register file commits at the end of N+1.
- Address 0: any request with wa==0 is never issued (we stays 0).
  - An ALU request to r0 counts as no ALU request.
  - A load to r0 is accepted and dropped.
- Arbitration each cycle, in priority order:
  1. ALU request (alu_we && alu_wa!=0) -> issue ALU.
  2. Otherwise, FIFO non-empty -> pop the head and issue it.
  3. Otherwise, handshake load with ld_wa!=0 -> issue it directly (bypass, not enqueued).
  4. Otherwise -> we=0 next cycle.
- ld_ready = (count < DEPTH), computed from registered count only.
  - When full, ld_ready stays 0 even if a pop occurs in the same cycle.
- A handshaken load that is not bypassed and not dropped is enqueued at the tail.
  - Simultaneous push+pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- WAW ordering: ALU results are younger than any load already in flight.
  - When an ALU request issues to address X, every valid FIFO entry with addr X is invalidated in the same cycle.
  - Invalidated entries are popped silently when they reach the head; the pop consumes the cycle, with no write issued.
  - An incoming load in the same cycle with ld_wa==alu_wa is accepted and dropped.
- Hazards:
  - hz1 = ra1!=0 && (ra1 matches a valid FIFO entry, or (we && wa==ra1)). hz2 is identical for ra2.
  - Hazards are combinational from registered state only.
  - The current-cycle alu_* and ld_* inputs do not contribute.
- count includes invalidated-but-unpopped entries.

Decomposition:
- Shared package rf_pkg holds:
  - the AW/DW constants;
  - a wb_req_t struct {valid, addr, data};
  - the constant RF_ZERO_ADDR=0.
- One natural sub-module, wb_fifo:
  - DEPTH-entry circular buffer with per-entry valid, an invalidate-by-address port, and address-match outputs for two query addresses.
- The arbiter and the output register stay in the top module.

Test Plan:
- ALU only: alu_we=1, alu_wa=9, alu_wd=7 in cycle 0 -> we=1, wa=9, wd=7 in cycle 1. alu_wa=0 -> we=0.
- Load bypass: FIFO empty, no ALU, ld_valid=1, ld_wa=11, ld_wd=0x44 -> ld_ready=1, then we=1, wa=11, wd=0x44 next cycle, and count stays 0.
- Contention/fill:
  - Stimulus: ALU writes every cycle for 6 cycles while the load source offers 6 results to r1..r6.
  - Required: count reaches 4 and ld_ready=0 from that point.
  - After ALU stops: r1..r4 drain in order, one per cycle, then the remaining loads are accepted.
- WAW kill:
  - Stimulus: queue a load to r5 (data 0xAA), then ALU writes r5=0xBB.
  - Required: exactly one write to r5 with wd=0xBB, then a drain cycle with we=0, and count returns to 0.
- Hazard: queue a load to r9 and set ra1=9, ra2=0 -> hz1=1, hz2=0 until the cycle after r9 is committed, then hz1=0.
- Async reset mid-drain:
  - Stimulus: rst_n=0 with 3 entries queued.
  - Required: we=0 and count=0 immediately, without waiting for a clock edge, and no queued write appears after release.
